// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS-style fetch front end.
// Holds the instruction width, the NOP encoding, the PC alignment mask and the fetch-entry record.
package mips_pkg;

  localparam int          INST_W        = 32;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue: DEPTH-entry circular FIFO of fetch entries with push, pop and flush.
// Flush wins over push and pop; the head entry is read combinationally from the read pointer.
import mips_pkg::*;

module ifetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t         mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;

  // Storage carries no reset; entries only become visible through count.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: sequences the fetch PC, fills the prefetch queue from a
// combinational instruction memory and presents the queue head to decode.
import mips_pkg::*;

module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          DEPTH     = 4,
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [31:0]       imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              stall,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      fetch_pc;
  logic [31:0]      seq_pc;
  logic [31:0]      target_pc;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             push;
  logic             pop;
  fetch_entry_t     wr_entry;
  fetch_entry_t     head;

  assign full       = (count == CNT_W'(DEPTH));
  assign inst_valid = (count != '0);

  // Redirect suppresses both queue ports; the flush below discards everything.
  assign pop  = inst_valid && !stall && !redirect;
  assign push = !redirect && (!full || pop);

  always_comb begin
    seq_pc = fetch_pc + 32'd4;
    if (seq_pc >= 32'(MEM_BYTES)) begin
      seq_pc = '0;
    end
    target_pc = (redirect_pc & PC_ALIGN_MASK) % 32'(MEM_BYTES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= target_pc;
    end else if (push) begin
      fetch_pc <= seq_pc;
    end
  end

  assign wr_entry.inst = imem_rdata;
  assign wr_entry.pc   = fetch_pc;

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (redirect),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

  // Empty queue presents a NOP at pc 0 so reset and flush states read as all-zero.
  assign imem_addr = fetch_pc;
  assign inst      = inst_valid ? head.inst : NOP_WORD;
  assign inst_pc   = inst_valid ? head.pc   : 32'h0;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: a vector table for steady-state flow, stall, redirect and
// wrap, plus hand sequences for fill-from-reset, redirect with a partly full queue and mid-run reset.
module tb_ifetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int passed;
  int total;

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        st;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t        vec [22];
  logic [31:0] exp_q [$];

  ifetch_ctrl #(
    .RESET_PC  (32'h0),
    .DEPTH     (4),
    .MEM_BYTES (128)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h2002_0005;
      32'd4:   return 32'h2003_000C;
      32'd68:  return 32'h8C09_0050;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_vec(input int i, input logic rd, input logic [31:0] rpc, input logic st,
                         input logic ev, input logic [31:0] epc, input logic [31:0] eaddr);
    vec[i].rd    = rd;
    vec[i].rpc   = rpc;
    vec[i].st    = st;
    vec[i].ev    = ev;
    vec[i].epc   = epc;
    vec[i].eaddr = eaddr;
  endtask

  initial begin
    passed = 0;
    total  = 0;

    //           i   rd  rpc  st  ev  head_pc next_addr
    set_vec( 0, 0,   0, 0, 1,   0,   4);
    set_vec( 1, 0,   0, 0, 1,   4,   8);
    set_vec( 2, 0,   0, 0, 1,   8,  12);
    set_vec( 3, 0,   0, 1, 1,   8,  16);
    set_vec( 4, 0,   0, 1, 1,   8,  20);
    set_vec( 5, 0,   0, 1, 1,   8,  24);
    set_vec( 6, 0,   0, 1, 1,   8,  24);
    set_vec( 7, 0,   0, 0, 1,  12,  28);
    set_vec( 8, 0,   0, 0, 1,  16,  32);
    set_vec( 9, 0,   0, 0, 1,  20,  36);
    set_vec(10, 0,   0, 0, 1,  24,  40);
    set_vec(11, 1,  68, 0, 0,   0,  68);
    set_vec(12, 0,   0, 0, 1,  68,  72);
    set_vec(13, 1,  69, 1, 0,   0,  68);
    set_vec(14, 0,   0, 0, 1,  68,  72);
    set_vec(15, 1, 124, 0, 0,   0, 124);
    set_vec(16, 0,   0, 0, 1, 124,   0);
    set_vec(17, 0,   0, 0, 1,   0,   4);
    set_vec(18, 0,   0, 0, 1,   4,   8);
    set_vec(19, 1, 200, 0, 0,   0,  72);
    set_vec(20, 1,   8, 0, 0,   0,   8);
    set_vec(21, 0,   0, 0, 1,   8,  12);

    // Reset values held while rst_n is low
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    step();
    step();
    check("reset_valid", {31'b0, inst_valid}, 32'h0);
    check("reset_inst", inst, 32'h0);
    check("reset_pc", inst_pc, 32'h0);
    check("reset_addr", imem_addr, 32'h0);
    rst_n = 1'b1;

    // Table-driven flow
    for (int i = 0; i < 22; i++) begin
      redirect    = vec[i].rd;
      redirect_pc = vec[i].rpc;
      stall       = vec[i].st;
      step();
      check($sformatf("vec%0d_valid", i), {31'b0, inst_valid}, {31'b0, vec[i].ev});
      check($sformatf("vec%0d_pc", i), inst_pc, vec[i].epc);
      check($sformatf("vec%0d_inst", i), inst, vec[i].ev ? mem_word(vec[i].epc) : 32'h0);
      check($sformatf("vec%0d_addr", i), imem_addr, vec[i].eaddr);
    end
    redirect = 1'b0;
    stall    = 1'b0;

    // Stall from reset: queue saturates, then drains in order without gaps
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("fill%0d_inst", i), inst, 32'h2002_0005);
      check($sformatf("fill%0d_valid", i), {31'b0, inst_valid}, 32'h1);
    end
    check("fill_addr", imem_addr, 32'd16);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check($sformatf("drain%0d_pc", i), inst_pc, e);
      check($sformatf("drain%0d_inst", i), inst, mem_word(e));
      step();
    end

    // Redirect with three queued entries and no stall: head is not consumed, queue flushed
    do_reset();
    stall = 1'b1;
    step();
    step();
    step();
    check("q3_addr", imem_addr, 32'd12);
    check("q3_pc", inst_pc, 32'd0);
    stall       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'd68;
    step();
    check("rd3_valid", {31'b0, inst_valid}, 32'h0);
    check("rd3_addr", imem_addr, 32'd68);
    redirect = 1'b0;
    step();
    check("rd3_tgt_pc", inst_pc, 32'd68);
    check("rd3_tgt_inst", inst, 32'h8C09_0050);
    step();
    check("rd3_next_pc", inst_pc, 32'd72);

    // Asynchronous reset mid-run with three entries queued
    do_reset();
    stall = 1'b1;
    step();
    step();
    step();
    check("ar_pre_valid", {31'b0, inst_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'b0, inst_valid}, 32'h0);
    check("ar_inst", inst, 32'h0);
    check("ar_pc", inst_pc, 32'h0);
    check("ar_addr", imem_addr, 32'h0);
    stall = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    check("ar_restart_valid", {31'b0, inst_valid}, 32'h1);
    check("ar_restart_pc", inst_pc, 32'h0);
    check("ar_restart_inst", inst, 32'h2002_0005);
    step();
    check("ar_second_pc", inst_pc, 32'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
